// File: rtl/caxi4interconnect_slave_slot_arbiter_if.sv
// Request/grant bundle between the master-control instances and the slave-slot arbiter.
// The "slave" modport is taken by the arbiter; the "master" modport is the requesting side.
interface caxi4interconnect_slave_slot_arbiter_if #(
  parameter int NUM_MASTERS       = 4,
  parameter int NUM_MASTERS_WIDTH = 2,
  parameter int NUM_SLAVES        = 4,
  parameter int NUM_SLAVES_WIDTH  = 2
);
  logic [NUM_MASTERS-1:0]                  masterValidQual;
  logic [NUM_MASTERS*NUM_SLAVES_WIDTH-1:0] masterSlaveID;
  logic [NUM_SLAVES-1:0]                   slaveReady;
  logic                                    grantValid;
  logic [NUM_MASTERS-1:0]                  grantOneHot;
  logic [NUM_MASTERS_WIDTH-1:0]            grantMaster;
  logic [NUM_SLAVES_WIDTH-1:0]             grantSlaveID;
  logic [NUM_MASTERS-1:0]                  openTransInc;

  modport master (
    output masterValidQual, masterSlaveID, slaveReady,
    input  grantValid, grantOneHot, grantMaster, grantSlaveID, openTransInc
  );

  modport slave (
    input  masterValidQual, masterSlaveID, slaveReady,
    output grantValid, grantOneHot, grantMaster, grantSlaveID, openTransInc
  );
endinterface

// File: rtl/caxi4interconnect_slave_slot_arbiter.sv
// Round-robin arbiter sharing one slave-side address slot between NUM_MASTERS masters.
// Holds each grant until the target slave accepts, then pulses openTransInc to the winner.
module caxi4interconnect_slave_slot_arbiter #(
  parameter int NUM_MASTERS       = 4,
  parameter int NUM_MASTERS_WIDTH = 2,
  parameter int NUM_SLAVES        = 4,
  parameter int NUM_SLAVES_WIDTH  = 2
) (
  input  logic                                 sysClk_i,
  input  logic                                 sysReset_i,
  caxi4interconnect_slave_slot_arbiter_if.slave slotBus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                        state_q, state_d;
  logic [NUM_MASTERS_WIDTH-1:0]  rrPtr_q, rrPtr_d;
  logic [NUM_MASTERS_WIDTH-1:0]  grantMaster_q, grantMaster_d;
  logic [NUM_SLAVES_WIDTH-1:0]   grantSlaveID_q, grantSlaveID_d;

  logic                          grantValid;
  logic [NUM_MASTERS-1:0]        grantOneHot;
  logic [NUM_MASTERS-1:0]        openTransInc;
  logic [NUM_MASTERS-1:0]        reqMasked;
  logic [NUM_SLAVES-1:0]         slaveReadyVec;
  logic [NUM_MASTERS_WIDTH-1:0]  searchBase;
  logic [NUM_MASTERS_WIDTH-1:0]  winner;
  logic [NUM_SLAVES_WIDTH-1:0]   winnerSlaveID;
  logic                          anyReq;
  logic                          accept;
  logic                          withdraw;

  assign slaveReadyVec = slotBus.slaveReady;
  assign grantValid    = (state_q == GRANT);
  assign grantOneHot   = grantValid ? (NUM_MASTERS'(1) << grantMaster_q) : '0;

  // The accept is combinational so the master sees its pulse in the accept cycle itself.
  assign accept   = grantValid && !sysReset_i && slaveReadyVec[grantSlaveID_q]
                    && slotBus.masterValidQual[grantMaster_q];
  assign withdraw = grantValid && !slotBus.masterValidQual[grantMaster_q];

  assign openTransInc = accept ? grantOneHot : '0;

  // A master whose transaction is accepted this cycle does not compete for the next slot.
  assign reqMasked  = slotBus.masterValidQual & ~openTransInc;
  assign anyReq     = |reqMasked;
  assign searchBase = grantValid ? grantMaster_q : rrPtr_q;

  // Descending scan so the closest requester after searchBase is written last and wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      if (reqMasked[(int'(searchBase) + i) % NUM_MASTERS]) begin
        winner = NUM_MASTERS_WIDTH'((int'(searchBase) + i) % NUM_MASTERS);
      end
    end
  end

  assign winnerSlaveID =
    slotBus.masterSlaveID[int'(winner)*NUM_SLAVES_WIDTH +: NUM_SLAVES_WIDTH];

  always_comb begin
    state_d        = state_q;
    rrPtr_d        = rrPtr_q;
    grantMaster_d  = grantMaster_q;
    grantSlaveID_d = grantSlaveID_q;
    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          state_d        = GRANT;
          grantMaster_d  = winner;
          grantSlaveID_d = winnerSlaveID;
        end
      end
      GRANT: begin
        if (accept) begin
          rrPtr_d = grantMaster_q;
          if (anyReq) begin
            grantMaster_d  = winner;
            grantSlaveID_d = winnerSlaveID;
          end else begin
            state_d        = IDLE;
            grantMaster_d  = '0;
            grantSlaveID_d = '0;
          end
        end else if (withdraw) begin
          state_d        = IDLE;
          grantMaster_d  = '0;
          grantSlaveID_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to the last master so master 0 is searched first.
  always_ff @(posedge sysClk_i) begin
    if (sysReset_i) begin
      state_q        <= IDLE;
      rrPtr_q        <= NUM_MASTERS_WIDTH'(NUM_MASTERS - 1);
      grantMaster_q  <= '0;
      grantSlaveID_q <= '0;
    end else begin
      state_q        <= state_d;
      rrPtr_q        <= rrPtr_d;
      grantMaster_q  <= grantMaster_d;
      grantSlaveID_q <= grantSlaveID_d;
    end
  end

  assign slotBus.grantValid   = grantValid;
  assign slotBus.grantOneHot  = grantOneHot;
  assign slotBus.grantMaster  = grantValid ? grantMaster_q : '0;
  assign slotBus.grantSlaveID = grantValid ? grantSlaveID_q : '0;
  assign slotBus.openTransInc = openTransInc;

endmodule

// File: tb/tb_caxi4interconnect_slave_slot_arbiter.sv
// Self-checking bench for the slave-slot arbiter: directed scenarios plus random traffic
// compared against a transaction-level round-robin reference model.
module tb_caxi4interconnect_slave_slot_arbiter;
  localparam int NM  = 4;
  localparam int NMW = 2;
  localparam int NS  = 4;
  localparam int NSW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  caxi4interconnect_slave_slot_arbiter_if #(
    .NUM_MASTERS(NM), .NUM_MASTERS_WIDTH(NMW), .NUM_SLAVES(NS), .NUM_SLAVES_WIDTH(NSW)
  ) bus ();

  caxi4interconnect_slave_slot_arbiter #(
    .NUM_MASTERS(NM), .NUM_MASTERS_WIDTH(NMW), .NUM_SLAVES(NS), .NUM_SLAVES_WIDTH(NSW)
  ) dut (
    .sysClk_i   (clk),
    .sysReset_i (rst),
    .slotBus    (bus)
  );

  int checksRun    = 0;
  int checksPassed = 0;

  // Reference model: who holds the slot, for which slave, and who was last served.
  bit mValid;
  int mOwner;
  int mSlave;
  int mPtr;

  function automatic int pickWinner(int ptr, logic [NM-1:0] req);
    for (int i = 1; i <= NM; i++) begin
      if (req[(ptr + i) % NM]) return (ptr + i) % NM;
    end
    return -1;
  endfunction

  task automatic resetModel();
    mValid = 1'b0;
    mOwner = 0;
    mSlave = 0;
    mPtr   = NM - 1;
  endtask

  // Packed observation: {grantValid, grantOneHot[3:0], grantMaster[1:0], grantSlaveID[1:0], openTransInc[3:0]}
  task automatic runCycle(input logic [3:0] req, input logic [7:0] ids, input logic [3:0] rdy,
                          input logic doReset, output logic [12:0] obs, output logic [12:0] exp);
    logic [3:0] eHot;
    logic [3:0] eInc;
    int w;
    rst                 = doReset;
    bus.masterValidQual = req;
    bus.masterSlaveID   = ids;
    bus.slaveReady      = rdy;
    @(negedge clk);
    obs  = {bus.grantValid, bus.grantOneHot, bus.grantMaster, bus.grantSlaveID, bus.openTransInc};
    eHot = mValid ? 4'(1 << mOwner) : 4'b0000;
    eInc = (mValid && rdy[mSlave] && req[mOwner] && !doReset) ? eHot : 4'b0000;
    exp  = {mValid, eHot, mValid ? 2'(mOwner) : 2'b00, mValid ? 2'(mSlave) : 2'b00, eInc};
    if (doReset) begin
      resetModel();
    end else if (!mValid || eInc != 4'b0000) begin
      if (eInc != 4'b0000) mPtr = mOwner;
      w = pickWinner(mPtr, req & ~eInc);
      if (w >= 0) begin
        mValid = 1'b1;
        mOwner = w;
        mSlave = int'(ids[w*2 +: 2]);
      end else begin
        mValid = 1'b0;
      end
    end else if (!req[mOwner]) begin
      mValid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] obs, exp;
    for (int c = 0; c < 2; c++) begin
      runCycle(4'b1111, 8'hE4, 4'b1111, 1'b1, obs, exp);
      checksRun++;
      if (obs !== 13'd0) $display("[TB] FAIL reset_outputs cyc%0d got=%h want=%h", c, obs, 13'd0);
      else checksPassed++;
    end
  endtask

  task automatic test_single();
    logic [12:0] obs, exp;
    runCycle(4'b0001, 8'b00_00_00_10, 4'b0100, 1'b0, obs, exp);
    checksRun++;
    if (obs !== exp) $display("[TB] FAIL single_idle got=%h want=%h", obs, exp);
    else checksPassed++;
    runCycle(4'b0001, 8'b00_00_00_10, 4'b0100, 1'b0, obs, exp);
    checksRun++;
    if (obs !== 13'b1_0001_00_10_0001) $display("[TB] FAIL single_grant got=%h want=%h", obs, 13'b1_0001_00_10_0001);
    else checksPassed++;
    runCycle(4'b0000, 8'b00_00_00_10, 4'b0100, 1'b0, obs, exp);
    checksRun++;
    if (obs !== 13'd0) $display("[TB] FAIL single_back_to_idle got=%h want=%h", obs, 13'd0);
    else checksPassed++;
  endtask

  task automatic test_back_to_back();
    logic [12:0] obs, exp;
    runCycle(4'b0000, 8'h00, 4'b0000, 1'b1, obs, exp);
    runCycle(4'b1111, 8'hE4, 4'b1111, 1'b0, obs, exp);
    for (int k = 0; k < 6; k++) begin
      runCycle(4'b1111, 8'hE4, 4'b1111, 1'b0, obs, exp);
      checksRun++;
      if (obs[7:6] !== 2'(k % NM) || obs[3:0] !== 4'(1 << (k % NM)))
        $display("[TB] FAIL b2b_order k=%0d got_master=%0d got_inc=%b want_master=%0d", k, obs[7:6], obs[3:0], k % NM);
      else checksPassed++;
      checksRun++;
      if (obs !== exp) $display("[TB] FAIL b2b_model k=%0d got=%h want=%h", k, obs, exp);
      else checksPassed++;
    end
  endtask

  task automatic test_hold();
    logic [12:0] obs, exp;
    runCycle(4'b0000, 8'h00, 4'b0000, 1'b1, obs, exp);
    runCycle(4'b0010, 8'b00_00_11_00, 4'b0000, 1'b0, obs, exp);
    for (int c = 0; c < 5; c++) begin
      if (c < 2) runCycle(4'b0010, 8'b00_00_11_00, 4'b0000, 1'b0, obs, exp);
      else       runCycle(4'b0010, 8'b00_00_00_00, 4'b0001, 1'b0, obs, exp);
      checksRun++;
      if (obs !== 13'b1_0010_01_11_0000) $display("[TB] FAIL hold_stable cyc%0d got=%h want=%h", c, obs, 13'b1_0010_01_11_0000);
      else checksPassed++;
    end
    runCycle(4'b0010, 8'b00_00_00_00, 4'b1000, 1'b0, obs, exp);
    checksRun++;
    if (obs !== 13'b1_0010_01_11_0010) $display("[TB] FAIL hold_accept got=%h want=%h", obs, 13'b1_0010_01_11_0010);
    else checksPassed++;
    runCycle(4'b0000, 8'b00_00_00_00, 4'b1000, 1'b0, obs, exp);
    checksRun++;
    if (obs !== exp) $display("[TB] FAIL hold_after got=%h want=%h", obs, exp);
    else checksPassed++;
  endtask

  task automatic test_withdraw();
    logic [12:0] obs, exp;
    runCycle(4'b0000, 8'h00, 4'b0000, 1'b1, obs, exp);
    runCycle(4'b0100, 8'b00_01_00_00, 4'b0000, 1'b0, obs, exp);
    runCycle(4'b0100, 8'b00_01_00_00, 4'b0000, 1'b0, obs, exp);
    checksRun++;
    if (obs[12] !== 1'b1 || obs[7:6] !== 2'd2) $display("[TB] FAIL withdraw_grant got=%h", obs);
    else checksPassed++;
    runCycle(4'b0000, 8'b00_01_00_00, 4'b1111, 1'b0, obs, exp);
    checksRun++;
    if (obs[3:0] !== 4'b0000) $display("[TB] FAIL withdraw_no_pulse got=%b want=0000", obs[3:0]);
    else checksPassed++;
    runCycle(4'b1001, 8'b00_01_00_00, 4'b0000, 1'b0, obs, exp);
    checksRun++;
    if (obs !== 13'd0) $display("[TB] FAIL withdraw_released got=%h want=%h", obs, 13'd0);
    else checksPassed++;
    runCycle(4'b1001, 8'b00_01_00_00, 4'b0000, 1'b0, obs, exp);
    checksRun++;
    if (obs[12] !== 1'b1 || obs[7:6] !== 2'd0) $display("[TB] FAIL withdraw_ptr_kept got_master=%0d want=0", obs[7:6]);
    else checksPassed++;
  endtask

  task automatic test_reset_mid_grant();
    logic [12:0] obs, exp;
    runCycle(4'b0000, 8'h00, 4'b0000, 1'b1, obs, exp);
    runCycle(4'b0010, 8'hE4, 4'b0000, 1'b0, obs, exp);
    runCycle(4'b0010, 8'hE4, 4'b1111, 1'b0, obs, exp);
    runCycle(4'b0100, 8'hE4, 4'b0000, 1'b0, obs, exp);
    runCycle(4'b0100, 8'hE4, 4'b0000, 1'b0, obs, exp);
    checksRun++;
    if (obs !== exp) $display("[TB] FAIL rstgrant_pre got=%h want=%h", obs, exp);
    else checksPassed++;
    runCycle(4'b0100, 8'hE4, 4'b1111, 1'b1, obs, exp);
    checksRun++;
    if (obs[3:0] !== 4'b0000) $display("[TB] FAIL rstgrant_no_pulse got=%b want=0000", obs[3:0]);
    else checksPassed++;
    runCycle(4'b1111, 8'hE4, 4'b0000, 1'b0, obs, exp);
    checksRun++;
    if (obs !== 13'd0) $display("[TB] FAIL rstgrant_cleared got=%h want=%h", obs, 13'd0);
    else checksPassed++;
    runCycle(4'b1111, 8'hE4, 4'b0000, 1'b0, obs, exp);
    checksRun++;
    if (obs[12] !== 1'b1 || obs[7:6] !== 2'd0) $display("[TB] FAIL rstgrant_first_master got=%0d want=0", obs[7:6]);
    else checksPassed++;
  endtask

  task automatic test_wrap();
    logic [12:0] obs, exp;
    runCycle(4'b0000, 8'h00, 4'b0000, 1'b1, obs, exp);
    runCycle(4'b1001, 8'hE4, 4'b1111, 1'b0, obs, exp);
    runCycle(4'b1001, 8'hE4, 4'b1111, 1'b0, obs, exp);
    checksRun++;
    if (obs[7:6] !== 2'd0 || obs[3:0] !== 4'b0001) $display("[TB] FAIL wrap_first got=%h", obs);
    else checksPassed++;
    runCycle(4'b1001, 8'hE4, 4'b1111, 1'b0, obs, exp);
    checksRun++;
    if (obs[7:6] !== 2'd3 || obs[3:0] !== 4'b1000) $display("[TB] FAIL wrap_second got=%h", obs);
    else checksPassed++;
  endtask

  task automatic test_random();
    logic [12:0] obs, exp;
    for (int c = 0; c < 400; c++) begin
      runCycle(4'($urandom), 8'($urandom), 4'($urandom), ($urandom_range(0, 39) == 0), obs, exp);
      checksRun++;
      if (obs !== exp) $display("[TB] FAIL random cyc%0d got=%h want=%h", c, obs, exp);
      else checksPassed++;
    end
  endtask

  initial begin
    rst                 = 1'b1;
    bus.masterValidQual = '0;
    bus.masterSlaveID   = '0;
    bus.slaveReady      = '0;
    resetModel();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_withdraw();
    test_reset_mid_grant();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end
endmodule
